// File: rtl/mining_scheduler_pkg.sv
// Shared types and helpers for the miner: scheduler state encoding, header/digest
// widths, and the byte-reversal used for nonce insertion and digest comparison.
package miner_pkg;

    localparam int HDR_PREFIX_W = 608;
    localparam int HDR_W        = 640;
    localparam int DIGEST_W     = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CHECK,
        ST_REPORT,
        ST_DONE
    } state_t;

    // Reverses the byte order of the low nbytes bytes of v; upper bytes return as zero.
    function automatic logic [DIGEST_W-1:0] byte_rev(input logic [DIGEST_W-1:0] v,
                                                     input int nbytes);
        logic [DIGEST_W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGEST_W/8; i++) begin
            for (int j = 0; j < DIGEST_W/8; j++) begin
                if (i < nbytes && j == nbytes - 1 - i) r[8*i +: 8] = v[8*j +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] nonce_le(input logic [31:0] n);
        logic [DIGEST_W-1:0] t;
        t = byte_rev({{(DIGEST_W-32){1'b0}}, n}, 4);
        return t[31:0];
    endfunction

endpackage

// File: rtl/mining_scheduler_if.sv
// Job, hash-core and result signals of the mining scheduler. The master modport is
// the scheduler side; the slave modport is the job source / hash core / consumer side.
interface mining_scheduler_if #(parameter int NONCE_W = 32, parameter int CNT_W = 32);
    import miner_pkg::*;

    // Handshakes: a job transfers on a rising edge where job_valid && job_ready;
    // a found nonce transfers where found_valid && found_ack; found_valid holds
    // its nonce stable until that edge. hash_start/hash_done/exhausted are pulses.
    logic                    job_valid;
    logic                    job_ready;
    logic [HDR_PREFIX_W-1:0] job_header;
    logic [DIGEST_W-1:0]     job_target;
    logic [NONCE_W-1:0]      job_nonce_start;
    logic [NONCE_W-1:0]      job_nonce_end;
    logic                    abort;
    logic                    hash_start;
    logic [HDR_W-1:0]        hash_header;
    logic                    hash_done;
    logic [DIGEST_W-1:0]     hash_digest;
    logic                    found_valid;
    logic [NONCE_W-1:0]      found_nonce;
    logic                    found_ack;
    logic                    exhausted;
    logic                    timeout_err;
    logic                    busy;
    logic [CNT_W-1:0]        hash_count;

    modport master (
        input  job_valid, job_header, job_target, job_nonce_start, job_nonce_end,
               abort, hash_done, hash_digest, found_ack,
        output job_ready, hash_start, hash_header, found_valid, found_nonce,
               exhausted, timeout_err, busy, hash_count
    );

    modport slave (
        output job_valid, job_header, job_target, job_nonce_start, job_nonce_end,
               abort, hash_done, hash_digest, found_ack,
        input  job_ready, hash_start, hash_header, found_valid, found_nonce,
               exhausted, timeout_err, busy, hash_count
    );

endinterface

// File: rtl/mining_scheduler_target_compare.sv
// Digest-versus-target check: the SHA-order digest is read as a little-endian
// integer and must not exceed the big-endian target.
module target_compare
    import miner_pkg::*;
(
    input  logic [DIGEST_W-1:0] digest,
    input  logic [DIGEST_W-1:0] target,
    output logic                hit
);

    logic [DIGEST_W-1:0] val;

    assign val = byte_rev(digest, DIGEST_W/8);
    assign hit = (val <= target);

endmodule

// File: rtl/mining_scheduler.sv
// Walks one job's inclusive nonce range through a shared double-SHA256 core,
// reporting winning nonces, range exhaustion and core timeouts.
module mining_scheduler
    import miner_pkg::*;
#(
    parameter int NONCE_W     = 32,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    mining_scheduler_if.master bus,
    output state_t      dbg_state
);

    localparam int WC_W = $clog2(TIMEOUT_CYC + 1);

    state_t                  state, state_n;
    logic [NONCE_W-1:0]      nonce_q, end_q, nonce_inc;
    logic [HDR_PREFIX_W-1:0] prefix_q;
    logic [DIGEST_W-1:0]     target_q, digest_q;
    logic [HDR_W-1:0]        header_q;
    logic [WC_W-1:0]         wait_cnt;
    logic [CNT_W-1:0]        hash_count_q;
    logic                    timeout_q;
    logic                    hit, last, accept, advance, wait_expired;

    target_compare u_cmp (
        .digest (digest_q),
        .target (target_q),
        .hit    (hit)
    );

    // abort beats a simultaneous job offer in IDLE
    assign accept       = (state == ST_IDLE) && bus.job_valid && !bus.abort;
    assign last         = (nonce_q == end_q);
    assign nonce_inc    = nonce_q + 1'b1;
    // wait_cnt counts cycles since hash_start, so the flag rises TIMEOUT_CYC cycles after it
    assign wait_expired = (wait_cnt == WC_W'(TIMEOUT_CYC - 1));
    assign advance      = !bus.abort && !last &&
                          (((state == ST_CHECK) && !hit) ||
                           ((state == ST_REPORT) && bus.found_ack));

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (accept) state_n = ST_LAUNCH;
            ST_LAUNCH: state_n = ST_WAIT;
            ST_WAIT: begin
                if (bus.hash_done)     state_n = ST_CHECK;
                else if (wait_expired) state_n = ST_IDLE;
            end
            ST_CHECK: begin
                if (hit)       state_n = ST_REPORT;
                else if (last) state_n = ST_DONE;
                else           state_n = ST_LAUNCH;
            end
            ST_REPORT: if (bus.found_ack) state_n = last ? ST_DONE : ST_LAUNCH;
            ST_DONE:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
        if (bus.abort) state_n = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_q      <= '0;
            end_q        <= '0;
            prefix_q     <= '0;
            target_q     <= '0;
            digest_q     <= '0;
            header_q     <= '0;
            wait_cnt     <= '0;
            hash_count_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            if (accept) begin
                prefix_q     <= bus.job_header;
                target_q     <= bus.job_target;
                nonce_q      <= bus.job_nonce_start;
                end_q        <= bus.job_nonce_end;
                header_q     <= {bus.job_header, nonce_le(bus.job_nonce_start)};
                hash_count_q <= '0;
                timeout_q    <= 1'b0;
            end
            // header only changes between hashes, never while the core is using it
            if (advance) begin
                nonce_q  <= nonce_inc;
                header_q <= {prefix_q, nonce_le(nonce_inc)};
            end
            if (state == ST_LAUNCH)    wait_cnt <= WC_W'(1);
            else if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
            if ((state == ST_WAIT) && bus.hash_done) digest_q <= bus.hash_digest;
            if ((state == ST_CHECK) && !bus.abort) hash_count_q <= hash_count_q + 1'b1;
            if ((state == ST_WAIT) && !bus.hash_done && wait_expired && !bus.abort)
                timeout_q <= 1'b1;
        end
    end

    assign bus.job_ready   = (state == ST_IDLE);
    assign bus.busy        = (state != ST_IDLE);
    assign bus.hash_start  = (state == ST_LAUNCH);
    assign bus.hash_header = header_q;
    assign bus.found_valid = (state == ST_REPORT);
    assign bus.found_nonce = (state == ST_REPORT) ? nonce_q : '0;
    assign bus.exhausted   = (state == ST_DONE);
    assign bus.timeout_err = timeout_q;
    assign bus.hash_count  = hash_count_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_mining_scheduler.sv
// Directed bench for mining_scheduler with a behavioural hash core, an auto-acking
// result consumer and a queue-based scoreboard checked by an independent monitor.
module tb_mining_scheduler;
  import miner_pkg::*;

  localparam int CNT_W = 32;
  localparam int TO    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  state_t dbg_state;

  always #5 clk = ~clk;

  mining_scheduler_if #(.NONCE_W(32), .CNT_W(CNT_W)) bus ();

  mining_scheduler #(.NONCE_W(32), .TIMEOUT_CYC(TO), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int core_lat = 2;
  int ack_delay = 2;
  bit core_silent = 1'b0;

  logic [31:0]  exp_hdr_q[$];
  logic [31:0]  exp_found_q[$];
  logic [31:0]  exp_cnt_q[$];
  logic [255:0] dig_q[$];
  int           start_cyc_q[$];
  logic [607:0] cur_hdr = '0;
  logic [31:0]  mon_e;
  logic [255:0] core_d;

  localparam logic [255:0] ONES = {256{1'b1}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_hdr(input logic [607:0] act, input logic [607:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL hdr_prefix: got %0h expected %0h", act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a start, a found handshake or exhausted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.hash_start) begin
        start_cyc_q.push_back(cyc);
        check("start_expected", 32'(exp_hdr_q.size() != 0), 32'd1);
        if (exp_hdr_q.size() != 0) begin
          mon_e = exp_hdr_q.pop_front();
          check("hdr_nonce", bus.hash_header[31:0], mon_e);
          check_hdr(bus.hash_header[639:32], cur_hdr);
        end
      end
      if (bus.found_valid && bus.found_ack) begin
        check("found_expected", 32'(exp_found_q.size() != 0), 32'd1);
        if (exp_found_q.size() != 0) begin
          mon_e = exp_found_q.pop_front();
          check("found_nonce", bus.found_nonce, mon_e);
        end
      end
      if (bus.exhausted) begin
        check("exhausted_expected", 32'(exp_cnt_q.size() != 0), 32'd1);
        check("exhausted_vs_found", 32'(bus.found_valid), 32'd0);
        if (exp_cnt_q.size() != 0) begin
          mon_e = exp_cnt_q.pop_front();
          check("count_at_exhausted", bus.hash_count, mon_e);
        end
      end
    end
  end

  // Hash core model: one request at a time, answers core_lat cycles after hash_start.
  initial begin
    bus.hash_done   = 1'b0;
    bus.hash_digest = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.hash_start && !core_silent) begin
        core_d = (dig_q.size() != 0) ? dig_q.pop_front() : ONES;
        repeat (core_lat) begin @(posedge clk); #1; end
        bus.hash_done   = 1'b1;
        bus.hash_digest = core_d;
        @(posedge clk); #1;
        bus.hash_done = 1'b0;
      end
    end
  end

  // Result consumer: acknowledges found nonces after ack_delay cycles.
  initial begin
    bus.found_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.found_valid) begin
        repeat (ack_delay) begin @(posedge clk); #1; end
        bus.found_ack = 1'b1;
        @(posedge clk); #1;
        bus.found_ack = 1'b0;
      end
    end
  end

  task automatic send_job(input logic [607:0] hdr, input logic [255:0] tgt,
                          input logic [31:0] s, input logic [31:0] e);
    bit got;
    got = 1'b0;
    cur_hdr = hdr;
    @(posedge clk); #1;
    bus.job_header      = hdr;
    bus.job_target      = tgt;
    bus.job_nonce_start = s;
    bus.job_nonce_end   = e;
    bus.job_valid       = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.job_ready && !bus.abort) got = 1'b1;
    end
    check("job_accepted", 32'(got), 32'd1);
    @(posedge clk); #1;
    bus.job_valid = 1'b0;
    @(negedge clk);
    check("launch_latency", 32'(bus.hash_start), 32'd1);
    check("timeout_cleared", 32'(bus.timeout_err), 32'd0);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (dbg_state == ST_IDLE) ok = 1'b1;
    end
    check("reach_idle", 32'(ok), 32'd1);
    check("sb_hdr_drained", 32'(exp_hdr_q.size()), 32'd0);
    check("sb_found_drained", 32'(exp_found_q.size()), 32'd0);
    check("sb_cnt_drained", 32'(exp_cnt_q.size()), 32'd0);
  endtask

  task automatic wait_start();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.hash_start) ok = 1'b1;
    end
    check("second_start_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    bus.job_valid = 1'b0;
    bus.abort = 1'b0;
    bus.job_header = '0;
    bus.job_target = '0;
    bus.job_nonce_start = '0;
    bus.job_nonce_end = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_job_ready", 32'(bus.job_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hash_start", 32'(bus.hash_start), 32'd0);
    check("rst_found_valid", 32'(bus.found_valid), 32'd0);
    check("rst_exhausted", 32'(bus.exhausted), 32'd0);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);
    check("rst_hash_count", bus.hash_count, 32'd0);
    check("rst_header_lo", bus.hash_header[31:0], 32'd0);
    check_hdr(bus.hash_header[639:32], '0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;

    // Single nonce hit on the last nonce: exhausted only after ack
    exp_hdr_q.push_back(32'h05000000);
    dig_q.push_back(256'h1);
    exp_found_q.push_back(32'h5);
    exp_cnt_q.push_back(32'd1);
    send_job({19{32'hA5C3_0F12}}, ONES, 32'h5, 32'h5);
    wait_idle();
    check("hit_count", bus.hash_count, 32'd1);

    // Miss range with nonce insertion and turnaround timing
    start_cyc_q.delete();
    foreach (exp_hdr_q[i]) exp_hdr_q.delete();
    exp_hdr_q.push_back(32'h10000000);
    exp_hdr_q.push_back(32'h11000000);
    exp_hdr_q.push_back(32'h12000000);
    exp_hdr_q.push_back(32'h13000000);
    for (int i = 0; i < 4; i++) dig_q.push_back({8'h77, 240'h0, 8'(i + 1)});
    exp_cnt_q.push_back(32'd4);
    send_job({19{32'h1234_5678}}, '0, 32'h10, 32'h13);
    wait_idle();
    check("miss_found_valid", 32'(bus.found_valid), 32'd0);
    check("miss_start_count", 32'(start_cyc_q.size()), 32'd4);
    for (int i = 1; i < start_cyc_q.size(); i++)
      check("start_interval", 32'(start_cyc_q[i] - start_cyc_q[i-1]), 32'd4);

    // Wrapping range
    exp_hdr_q.push_back(32'hFEFFFFFF);
    exp_hdr_q.push_back(32'hFFFFFFFF);
    exp_hdr_q.push_back(32'h00000000);
    exp_hdr_q.push_back(32'h01000000);
    for (int i = 0; i < 4; i++) dig_q.push_back(ONES);
    exp_cnt_q.push_back(32'd4);
    send_job({19{32'hDEAD_BEEF}}, '0, 32'hFFFFFFFE, 32'h00000001);
    wait_idle();

    // Hit in the middle of a range, scan continues afterwards
    exp_hdr_q.push_back(32'h20000000);
    exp_hdr_q.push_back(32'h21000000);
    exp_hdr_q.push_back(32'h22000000);
    dig_q.push_back(ONES);
    dig_q.push_back({8'h05, 248'h0});
    dig_q.push_back(ONES);
    exp_found_q.push_back(32'h21);
    exp_cnt_q.push_back(32'd3);
    send_job({19{32'h0BAD_F00D}}, 256'h100, 32'h20, 32'h22);
    wait_idle();

    // Digest byte order: MSB byte 01 reads as 1 (hit), 03 reads as 3 (miss vs target 2)
    exp_hdr_q.push_back(32'h07000000);
    dig_q.push_back({8'h01, 248'h0});
    exp_found_q.push_back(32'h7);
    exp_cnt_q.push_back(32'd1);
    send_job({19{32'h0000_0001}}, 256'h2, 32'h7, 32'h7);
    wait_idle();
    exp_hdr_q.push_back(32'h07000000);
    dig_q.push_back({8'h03, 248'h0});
    exp_cnt_q.push_back(32'd1);
    send_job({19{32'h0000_0002}}, 256'h2, 32'h7, 32'h7);
    wait_idle();

    // Abort during the second WAIT; the stale hash_done arrives 3 cycles after abort
    core_lat = 2;
    exp_hdr_q.push_back(32'h00000000);
    exp_hdr_q.push_back(32'h01000000);
    dig_q.push_back(ONES);
    dig_q.push_back({8'h00, 248'h1});
    send_job({19{32'hCAFE_0000}}, '0, 32'h0, 32'h9);
    @(posedge clk); #1;
    core_lat = 5;
    wait_start();
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_job_ready", 32'(bus.job_ready), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    repeat (6) @(negedge clk);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_found_valid", 32'(bus.found_valid), 32'd0);
    check("abort_count_held", bus.hash_count, 32'd1);
    check("abort_sb_hdr", 32'(exp_hdr_q.size()), 32'd0);
    core_lat = 2;

    // abort together with job_valid in IDLE: job refused
    @(posedge clk); #1;
    bus.job_valid = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.job_valid = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_wins_state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_wins_start", 32'(bus.hash_start), 32'd0);

    // Core timeout, then next job clears the sticky flag
    core_silent = 1'b1;
    exp_hdr_q.push_back(32'h44000000);
    send_job({19{32'h5555_AAAA}}, '0, 32'h44, 32'h50);
    bad = 1'b0;
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      if (bus.timeout_err) bad = 1'b1;
    end
    check("no_early_timeout", 32'(bad), 32'd0);
    @(negedge clk);
    check("timeout_set", 32'(bus.timeout_err), 32'd1);
    check("timeout_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) @(negedge clk);
    check("timeout_sticky", 32'(bus.timeout_err), 32'd1);
    core_silent = 1'b0;
    exp_hdr_q.push_back(32'h60000000);
    dig_q.push_back(ONES);
    exp_cnt_q.push_back(32'd1);
    send_job({19{32'h6666_7777}}, '0, 32'h60, 32'h60);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
